// File: rtl/register_array_ctrl.sv
// Command sequencer for the conjugation register array: LOAD/ROTATE/TOGGLE/READ drive load-enables and mux selects.
// Define CBA_CTRL_PERF_CNT_EN to add perf_cycles, a saturating count of busy cycles.
module register_array_ctrl #(
  parameter int num_qubit = 4,
  parameter int CW        = $clog2(num_qubit) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [num_qubit-1:0] cmd_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        col_idx,
  output logic                 ld_literal,
  output logic [num_qubit-1:0] ld_phase,
  output logic                 shift_rotate_literal,
  output logic                 shift_toggle_phase,
  output logic                 rotate_update_literal,
  output logic                 busy
`ifdef CBA_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROTATE = 3'd2,
    S_TOGGLE = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [num_qubit-1:0] mask_q, mask_d;
  logic                 last;

  assign last = (cnt_q == CW'(num_qubit - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // cnt holds at num_qubit-1 on the final step; it is cleared on the next accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mask_d = cmd_mask;
          cnt_d  = '0;
          case (cmd_op)
            2'd0:    state_d = S_LOAD;
            2'd1:    state_d = S_ROTATE;
            2'd2:    state_d = S_TOGGLE;
            default: state_d = S_READ;
          endcase
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          cnt_d = last ? cnt_q : cnt_q + CW'(1);
          if (last) state_d = S_IDLE;
        end
      end
      S_ROTATE: begin
        cnt_d = last ? cnt_q : cnt_q + CW'(1);
        if (last) state_d = S_IDLE;
      end
      S_TOGGLE: state_d = S_IDLE;
      S_READ: begin
        if (out_ready) begin
          cnt_d = last ? cnt_q : cnt_q + CW'(1);
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready             = (state_q == S_IDLE);
    busy                  = (state_q != S_IDLE);
    in_ready              = 1'b0;
    out_valid             = 1'b0;
    col_idx               = '0;
    ld_literal            = 1'b0;
    ld_phase              = '0;
    shift_rotate_literal  = 1'b0;
    shift_toggle_phase    = 1'b0;
    rotate_update_literal = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_literal = 1'b1;
          ld_phase   = '1;
        end
      end
      S_ROTATE: begin
        ld_literal           = 1'b1;
        shift_rotate_literal = 1'b1;
        col_idx              = cnt_q;
        for (int i = 0; i < num_qubit; i++) begin
          if (cnt_q == CW'(i)) rotate_update_literal = mask_q[i];
        end
      end
      S_TOGGLE: begin
        ld_phase           = mask_q;
        shift_toggle_phase = 1'b1;
      end
      S_READ: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ld_literal = 1'b1;
          ld_phase   = '1;
        end
      end
      default: ;
    endcase
  end

`ifdef CBA_CTRL_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (busy && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
